subbytes_iter: RTL and testbench

Iterative forward AES SubBytes engine for the encryption datapath; the counterpart of the combinational inverse stage used on the decryption side. Accepts a 128-bit state over a valid/ready handshake, substitutes one 32-bit word per cycle through four shared S-box units, and presents the 128-bit result over a second valid/ready handshake. It trades three extra cycles of latency for a quarter of the S-box area and computes the S-box arithmetically, with no 256-entry table.

---
 rtl/subbytes_iter_if.sv | 20 ++
 rtl/subbytes_iter.sv | 172 +++++++++++++++++
 tb/tb_subbytes_iter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/subbytes_iter_if.sv
// Handshake bundle for subbytes_iter: input block channel, output block channel and busy flag.
interface subbytes_iter_if;
  logic         inValid;
  logic         inReady;
  logic [127:0] state;
  logic         outValid;
  logic         outReady;
  logic [127:0] newState;
  logic         busy;

  modport slave (
    input  inValid, state, outReady,
    output inReady, outValid, newState, busy
  );

  modport master (
    output inValid, state, outReady,
    input  inReady, outValid, newState, busy
  );
endinterface

// File: rtl/subbytes_iter.sv
// Iterative AES SubBytes: one 32-bit word per cycle through four arithmetic S-box units.
// Optional macro SUBBYTES_INV_EN adds port 'inv' selecting the inverse S-box per block.
module subbytes_iter (
  input  logic           clk,
  input  logic           rst_n,
`ifdef SUBBYTES_INV_EN
  input  logic           inv,
`endif
  subbytes_iter_if.slave bus
);
  localparam int unsigned BLK_W    = 128;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned NBYTES_W = WORD_W / BYTE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_t;

  fsm_t              r_state;
  fsm_t              w_state_nxt;
  logic [1:0]        r_cnt;
  logic [BLK_W-1:0]  r_src;
  logic [BLK_W-1:0]  r_res;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;
  logic              w_in_ready_nxt;
  logic              w_out_valid_nxt;
  logic              w_busy_nxt;
  logic              w_accept;
  logic [WORD_W-1:0] w_src_word;
  logic [WORD_W-1:0] w_sub_word;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 = a^2 * a^4 * ... * a^128; naturally maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] affine_fwd(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    return affine_fwd(gf_inv(a));
  endfunction

`ifdef SUBBYTES_INV_EN
  logic r_inv;

  function automatic logic [7:0] affine_inv(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] a);
    return gf_inv(affine_inv(a));
  endfunction

  // Mode is captured with the block so a later toggle of inv cannot affect it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inv <= 1'b0;
    end else if (w_accept) begin
      r_inv <= inv;
    end
  end
`endif

  assign w_accept   = (r_state == ST_IDLE) && bus.inValid;
  assign w_src_word = r_src[{r_cnt, 5'd0} +: WORD_W];

  // Four shared S-box units on the current source word
  always_comb begin
    w_sub_word = '0;
    for (int b = 0; b < int'(NBYTES_W); b++) begin
`ifdef SUBBYTES_INV_EN
      w_sub_word[b*BYTE_W +: BYTE_W] = r_inv ? sbox_inv(w_src_word[b*BYTE_W +: BYTE_W])
                                             : sbox_fwd(w_src_word[b*BYTE_W +: BYTE_W]);
`else
      w_sub_word[b*BYTE_W +: BYTE_W] = sbox_fwd(w_src_word[b*BYTE_W +: BYTE_W]);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.inValid)   w_state_nxt = ST_RUN;
      ST_RUN:  if (r_cnt == 2'd3) w_state_nxt = ST_DONE;
      ST_DONE: if (bus.outReady)  w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so the flops mirror the FSM register
  always_comb begin
    w_in_ready_nxt  = 1'b0;
    w_out_valid_nxt = 1'b0;
    w_busy_nxt      = 1'b1;
    case (w_state_nxt)
      ST_IDLE: begin
        w_in_ready_nxt = 1'b1;
        w_busy_nxt     = 1'b0;
      end
      ST_DONE: w_out_valid_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src <= '0;
      r_res <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_src <= bus.state;
      r_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_res[{r_cnt, 5'd0} +: WORD_W] <= w_sub_word;
      r_cnt                          <= r_cnt + 2'd1;
    end
  end

  assign bus.inReady  = r_in_ready;
  assign bus.outValid = r_out_valid;
  assign bus.busy     = r_busy;
  assign bus.newState = r_res;
endmodule

// File: tb/tb_subbytes_iter.sv
// Self-checking bench for subbytes_iter: golden S-box built by brute-force inversion, cycle model, one monitor.
module tb_subbytes_iter;
  logic clk;
  logic rst_n;
  logic t_inv;
  logic [127:0] t_lit;
  logic t_hl;

  subbytes_iter_if ifc ();

  subbytes_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef SUBBYTES_INV_EN
    .inv   (t_inv),
`endif
    .bus   (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] stab [256];
  logic [7:0] itab [256];
  int n_cmp = 0;
  int n_err = 0;

  // Model state: one outstanding block, accepted at edge m_acc
  int cyc = 0;
  int m_acc = 0;
  bit m_pend = 0;
  logic [127:0] m_exp;
  logic [127:0] m_lit;
  bit m_hl = 0;
  bit pinned = 0;

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    logic [15:0] m;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) begin
      m = 16'h011b << (i - 8);
      if (p[i]) p = p ^ m;
    end
    return p[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] c;
    logic [7:0] iv;
    logic [7:0] s;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      iv = 8'h00;
      for (int y = 1; y < 256; y++) if (ref_mul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = iv[i] ^ iv[(i+4)%8] ^ iv[(i+5)%8] ^ iv[(i+6)%8] ^ iv[(i+7)%8] ^ c[i];
      stab[x] = s;
    end
    for (int x = 0; x < 256; x++) itab[stab[x]] = 8'(x);
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Cycle-level model: accept when idle, result due 4 edges later, retired on handshake
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = 0;
      m_hl   = 0;
    end else begin
      if (m_pend && (cyc >= m_acc + 4) && ifc.outReady) begin
        m_pend = 0;
      end else if (!m_pend && ifc.inValid) begin
        m_pend = 1;
        m_acc  = cyc + 1;
        m_lit  = t_lit;
        m_hl   = t_hl;
        for (int j = 0; j < 16; j++)
          m_exp[8*j +: 8] = t_inv ? itab[ifc.state[8*j +: 8]] : stab[ifc.state[8*j +: 8]];
      end
      cyc = cyc + 1;
    end
  end

  // Single compare process
  always @(negedge clk) begin
    bit ov;
    if (!pinned) begin
      pinned = 1;
      chk("pin_s00", 128'(stab[8'h00]), 128'h63);
      chk("pin_s53", 128'(stab[8'h53]), 128'hed);
      chk("pin_sff", 128'(stab[8'hff]), 128'h16);
      chk("pin_s01", 128'(stab[8'h01]), 128'h7c);
      chk("pin_i63", 128'(itab[8'h63]), 128'h00);
    end
    if (!rst_n) begin
      chk("rst_inReady",  128'(ifc.inReady),  128'h1);
      chk("rst_outValid", 128'(ifc.outValid), 128'h0);
      chk("rst_busy",     128'(ifc.busy),     128'h0);
      chk("rst_newState", ifc.newState,       128'h0);
    end else begin
      ov = m_pend && (cyc >= m_acc + 4);
      chk("inReady",  128'(ifc.inReady),  128'(!m_pend));
      chk("busy",     128'(ifc.busy),     128'(m_pend));
      chk("outValid", 128'(ifc.outValid), 128'(ov));
      if (ov) begin
        chk("newState", ifc.newState, m_exp);
        if (m_hl) chk("newState_literal", ifc.newState, m_lit);
      end
      if (m_pend && (cyc - m_acc == 60)) chk("timeout_pending", 128'(m_pend), 128'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] s, input logic iv, input logic [127:0] lit, input logic hl);
    int n;
    n = 0;
    while (!ifc.inReady && n < 80) begin
      step();
      n++;
    end
    ifc.state   = s;
    ifc.inValid = 1'b1;
    t_inv = iv;
    t_lit = lit;
    t_hl  = hl;
    step();
    ifc.inValid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_pend && n < 80) begin
      step();
      n++;
    end
  endtask

  logic [127:0] pat;
  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

  initial begin
    rst_n = 1'b1;
    t_inv = 1'b0;
    t_lit = '0;
    t_hl  = 1'b0;
    ifc.inValid  = 1'b0;
    ifc.outReady = 1'b1;
    ifc.state    = '0;
    build_tables();
    #2 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    send(FIPS_IN, 1'b0, FIPS_OUT, 1'b1);
    wait_idle();
    send({16{8'h00}}, 1'b0, {16{8'h63}}, 1'b1);
    wait_idle();
    send({16{8'h53}}, 1'b0, {16{8'hed}}, 1'b1);
    wait_idle();
    send({16{8'hff}}, 1'b0, {16{8'h16}}, 1'b1);
    wait_idle();

    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 16; j++) pat[8*j +: 8] = 8'(16*k + j);
      send(pat, 1'b0, '0, 1'b0);
    end
    wait_idle();

    // Backpressure: hold DONE, poke inValid, then release
    ifc.outReady = 1'b0;
    send(128'h00112233445566778899aabbccddeeff, 1'b0, '0, 1'b0);
    repeat (14) step();
    ifc.state   = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    ifc.inValid = 1'b1;
    repeat (2) step();
    ifc.inValid = 1'b0;
    repeat (2) step();
    ifc.outReady = 1'b1;
    wait_idle();
    step();

    // Reset after E2 of an in-flight block
    send(128'hcafebabe0123456789abcdeffedcba98, 1'b0, '0, 1'b0);
    repeat (2) step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
    send(FIPS_IN, 1'b0, FIPS_OUT, 1'b1);
    wait_idle();

`ifdef SUBBYTES_INV_EN
    send(FIPS_OUT, 1'b1, FIPS_IN, 1'b1);
    wait_idle();
    send({16{8'h63}}, 1'b1, {16{8'h00}}, 1'b1);
    wait_idle();
    send(FIPS_IN, 1'b0, FIPS_OUT, 1'b1);
    send(FIPS_OUT, 1'b1, FIPS_IN, 1'b1);
    wait_idle();
`endif

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
